// File: rtl/mult_hilo_unit.sv
// Multicycle unsigned multiplier with HI/LO result registers for an in-order pipeline.
// One radix-2 shift-add step per cycle; HI/LO change only when the full product is ready.
module mult_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hilo_rd_req,
    input  logic             mf_hilo_sel,
    output logic [WIDTH-1:0] hilo_rd,
    output logic             busy,
    output logic             stall,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   step_prod;
    logic                 last_step;

    // Multiplier bit cnt_q selects whether a_q is added into the upper half before the shift.
    always_comb begin
        addend    = b_q[cnt_q] ? a_q : '0;
        step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        step_prod = {step_sum, prod_q[WIDTH-1:1]};
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    // Handshake: start is a request that is accepted only in IDLE; while BUSY it is
    // dropped and stall holds the pipeline so the request is re-presented later.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    prod_d  = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                prod_d = step_prod;
                cnt_d  = cnt_q + 1'b1;
                if (last_step) begin
                    hi_d    = step_prod[2*WIDTH-1:WIDTH];
                    lo_d    = step_prod[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == BUSY);
    assign done    = done_q;
    assign stall   = busy & (hilo_rd_req | start);
    assign hilo_rd = mf_hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit: expected HI/LO products are queued when a
// multiply is issued and compared when the done pulse appears.
module tb_mult_hilo_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         hilo_rd_req;
    logic         mf_hilo_sel;
    logic [W-1:0] hilo_rd;
    logic         busy;
    logic         stall;
    logic         done;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_v;
    logic [2*W-1:0] exp_prev;
    int n;

    mult_hilo_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .hilo_rd_req(hilo_rd_req),
        .mf_hilo_sel(mf_hilo_sel),
        .hilo_rd    (hilo_rd),
        .busy       (busy),
        .stall      (stall),
        .done       (done)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Presents start for one cycle; returns at the negedge after the accepting edge.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        logic [2*W-1:0] p;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        if (push) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            exp_q.push_back(p);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the number of negedges (counting the current one as 1) until done is seen, or -1.
    task automatic wait_done(input int max, output int cnt);
        cnt = -1;
        for (int i = 1; i <= max; i++) begin
            if (done === 1'b1) begin
                cnt = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_expected();
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        else exp_v = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b1;
        hilo_rd_req = 1'b1;
        mf_hilo_sel = 1'b0;
        op_a        = W'($urandom_range(1, 1000));
        op_b        = W'($urandom_range(1, 1000));
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b stall=%b want 0 0 0", busy, done, stall);
        end
        checks++;
        if (hilo_rd !== '0) begin
            failures++;
            $display("FAIL reset_lo: got %h want 0", hilo_rd);
        end
        mf_hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_rd !== '0) begin
            failures++;
            $display("FAIL reset_hi: got %h want 0", hilo_rd);
        end
        start       = 1'b0;
        hilo_rd_req = 1'b0;
        mf_hilo_sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        drive_start(32'd3, 32'd5, 1'b1);
        mf_hilo_sel = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || hilo_rd !== '0) begin
                failures++;
                $display("FAIL basic_busy cycle %0d: busy=%b done=%b lo=%h want 1 0 0", i, busy, done, hilo_rd);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done cycle 33: done=%b busy=%b want 1 0", done, busy);
        end
        pop_expected();
        #1;
        checks++;
        if (hilo_rd !== exp_v[W-1:0]) begin
            failures++;
            $display("FAIL basic_lo: got %h want %h", hilo_rd, exp_v[W-1:0]);
        end
        mf_hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_rd !== exp_v[2*W-1:W]) begin
            failures++;
            $display("FAIL basic_hi: got %h want %h", hilo_rd, exp_v[2*W-1:W]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_extreme_operands();
        logic [W-1:0] ones;
        ones = '1;
        drive_start(ones, ones, 1'b1);
        wait_done(40, n);
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL max_latency: done at cycle %0d want 33", n);
        end
        pop_expected();
        mf_hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_rd !== exp_v[2*W-1:W]) begin
            failures++;
            $display("FAIL max_hi: got %h want %h", hilo_rd, exp_v[2*W-1:W]);
        end
        mf_hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_rd !== exp_v[W-1:0]) begin
            failures++;
            $display("FAIL max_lo: got %h want %h", hilo_rd, exp_v[W-1:0]);
        end
        drive_start('0, '0, 1'b1);
        wait_done(40, n);
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL zero_latency: done at cycle %0d want 33", n);
        end
        pop_expected();
        mf_hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_rd !== exp_v[2*W-1:W]) begin
            failures++;
            $display("FAIL zero_hi: got %h want %h", hilo_rd, exp_v[2*W-1:W]);
        end
        mf_hilo_sel = 1'b0;
    endtask

    task automatic test_read_during_busy();
        drive_start(32'hA000_0001, 32'h0000_0010, 1'b1);
        wait_done(40, n);
        pop_expected();
        exp_prev = exp_v;
        drive_start(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        hilo_rd_req = 1'b1;
        mf_hilo_sel = 1'b1;
        #1;
        for (int i = 1; i <= 32; i++) begin
            checks++;
            if (stall !== 1'b1 || hilo_rd !== exp_prev[2*W-1:W]) begin
                failures++;
                $display("FAIL rdbusy_hold cycle %0d: stall=%b hi=%h want 1 %h", i, stall, hilo_rd, exp_prev[2*W-1:W]);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL rdbusy_done: done=%b stall=%b want 1 0", done, stall);
        end
        pop_expected();
        checks++;
        if (hilo_rd !== exp_v[2*W-1:W]) begin
            failures++;
            $display("FAIL rdbusy_new_hi: got %h want %h", hilo_rd, exp_v[2*W-1:W]);
        end
        mf_hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_rd !== exp_v[W-1:0]) begin
            failures++;
            $display("FAIL rdbusy_new_lo: got %h want %h", hilo_rd, exp_v[W-1:0]);
        end
        hilo_rd_req = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        drive_start(32'h0000_DEAD, 32'h0000_BEEF, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        mf_hilo_sel = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hilo_rd !== '0) begin
            failures++;
            $display("FAIL rstmid_async: busy=%b done=%b hi=%h want 0 0 0", busy, done, hilo_rd);
        end
        mf_hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_rd !== '0) begin
            failures++;
            $display("FAIL rstmid_lo: got %h want 0", hilo_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rstmid_no_done: %0d done pulses want 0", seen);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        op_a  = 32'd2;
        op_b  = 32'd9;
        start = 1'b1;
        exp_q.push_back(64'd18);
        @(negedge clk);
        start = 1'b0;
        wait_done(40, n);
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL rst_first_edge_latency: done at cycle %0d want 33", n);
        end
        pop_expected();
        #1;
        checks++;
        if (hilo_rd !== exp_v[W-1:0]) begin
            failures++;
            $display("FAIL rst_first_edge_lo: got %h want %h", hilo_rd, exp_v[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        drive_start(32'd100, 32'd200, 1'b1);
        repeat (4) @(negedge clk);
        op_a  = 32'd7;
        op_b  = 32'd9;
        start = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ignored_stall: stall=%b busy=%b want 1 1", stall, busy);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(40, n);
        checks++;
        if (n != 28) begin
            failures++;
            $display("FAIL b2b_first_latency: done after %0d more cycles want 28", n);
        end
        pop_expected();
        mf_hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_rd !== exp_v[W-1:0]) begin
            failures++;
            $display("FAIL b2b_first_lo: got %h want %h", hilo_rd, exp_v[W-1:0]);
        end
        op_a  = 32'd7;
        op_b  = 32'd6;
        start = 1'b1;
        exp_q.push_back({{W{1'b0}}, op_a} * {{W{1'b0}}, op_b});
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done_cycle_stall: got %b want 0", stall);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(40, n);
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL b2b_second_latency: done at cycle %0d want 33", n);
        end
        pop_expected();
        checks++;
        if (hilo_rd !== exp_v[W-1:0] || hilo_rd !== 32'd42) begin
            failures++;
            $display("FAIL b2b_second_lo: got %0d want %0d", hilo_rd, exp_v[W-1:0]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int k = 0; k < 4; k++) begin
            a = {W'($urandom_range(0, 65535)), 16'h0} | W'($urandom_range(0, 65535));
            b = {W'($urandom_range(0, 65535)), 16'h0} | W'($urandom_range(0, 65535));
            drive_start(a, b, 1'b1);
            wait_done(40, n);
            pop_expected();
            mf_hilo_sel = 1'b1;
            #1;
            checks++;
            if (n != 33 || hilo_rd !== exp_v[2*W-1:W]) begin
                failures++;
                $display("FAIL random_hi %0d: cycle %0d hi=%h want 33 %h", k, n, hilo_rd, exp_v[2*W-1:W]);
            end
            mf_hilo_sel = 1'b0;
            #1;
            checks++;
            if (hilo_rd !== exp_v[W-1:0]) begin
                failures++;
                $display("FAIL random_lo %0d: got %h want %h", k, hilo_rd, exp_v[W-1:0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_extreme_operands();
        test_read_during_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
